// File: rtl/eth_tx_sched.sv
// Ethernet frame scheduler feeding the eth_tx byte interface: header, counting payload,
// commit, wait for the transmitter, inter-frame gap, repeated per frame count or until Stop.
module eth_tx_sched #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int unsigned GAP_CYCLES  = 48,
    parameter logic [10:0] MIN_PAYLOAD = 11'd46,
    parameter logic [10:0] MAX_PAYLOAD = 11'd1500
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        Stop,
    input  logic [7:0]  Frame_Count,
    input  logic [10:0] Payload_Len,
    input  logic        Tx_Busy,
    output logic [7:0]  Eth_Byte,
    output logic        Eth_Byte_Valid,
    output logic        Eth_Pkt_Rdy,
    output logic        Busy,
    output logic [15:0] Frames_Sent,
    output logic        Done
);

    typedef enum logic [2:0] {
        StIdle, StHdr, StPayload, StCommit, StWaitHi, StWaitLo, StGap
    } state_t;

    localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [15:0]  GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [10:0] r_cnt;
    logic [10:0] r_len;
    logic [7:0]  r_fcount;
    logic [7:0]  r_frame_idx;
    logic [15:0] r_frames_sent;
    logic [15:0] r_gap;
    logic        r_stop;
    logic [7:0]  r_byte;
    logic        r_valid;
    logic        r_pkt_rdy;
    logic        r_busy;
    logic        r_done;

    logic [10:0]  w_len;
    logic [111:0] w_hdr_shift;
    logic [7:0]   w_hdr_byte;
    logic [7:0]   w_pay_byte;
    logic         w_last_frame;

    always_comb begin
        w_len = Payload_Len;
        if (Payload_Len < MIN_PAYLOAD) begin
            w_len = MIN_PAYLOAD;
        end else if (Payload_Len > MAX_PAYLOAD) begin
            w_len = MAX_PAYLOAD;
        end
    end

    // r_cnt holds the index of the byte to be presented next.
    assign w_hdr_shift  = HDR_BYTES << {r_cnt[3:0], 3'b000};
    assign w_hdr_byte   = w_hdr_shift[111:104];
    assign w_pay_byte   = r_cnt[7:0] + r_frame_idx;
    assign w_last_frame = r_stop | Stop |
                          ((r_fcount != 8'd0) && (r_frames_sent == {8'h00, r_fcount}));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_len         <= '0;
            r_fcount      <= '0;
            r_frame_idx   <= '0;
            r_frames_sent <= '0;
            r_gap         <= '0;
            r_stop        <= 1'b0;
            r_byte        <= '0;
            r_valid       <= 1'b0;
            r_pkt_rdy     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_pkt_rdy <= 1'b0;
            r_done    <= 1'b0;
            if (r_state != StIdle && Stop) begin
                r_stop <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (Start && !Stop) begin
                        r_len         <= w_len;
                        r_fcount      <= Frame_Count;
                        r_frames_sent <= '0;
                        r_frame_idx   <= '0;
                        r_stop        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_valid       <= 1'b1;
                        r_byte        <= HDR_BYTES[111:104];
                        r_cnt         <= 11'd1;
                        r_state       <= StHdr;
                    end
                end
                StHdr: begin
                    if (r_cnt == 11'd14) begin
                        r_byte  <= r_frame_idx;
                        r_cnt   <= 11'd1;
                        r_state <= StPayload;
                    end else begin
                        r_byte <= w_hdr_byte;
                        r_cnt  <= r_cnt + 11'd1;
                    end
                end
                StPayload: begin
                    if (r_cnt == r_len) begin
                        r_valid     <= 1'b0;
                        r_byte      <= '0;
                        r_pkt_rdy   <= 1'b1;
                        r_frame_idx <= r_frame_idx + 8'd1;
                        if (r_frames_sent != 16'hFFFF) begin
                            r_frames_sent <= r_frames_sent + 16'd1;
                        end
                        r_state <= StCommit;
                    end else begin
                        r_byte <= w_pay_byte;
                        r_cnt  <= r_cnt + 11'd1;
                    end
                end
                StCommit: r_state <= StWaitHi;
                StWaitHi: begin
                    if (Tx_Busy) begin
                        r_state <= StWaitLo;
                    end
                end
                StWaitLo: begin
                    if (!Tx_Busy) begin
                        r_gap   <= '0;
                        r_state <= StGap;
                    end
                end
                StGap: begin
                    if (r_gap == GAP_LAST) begin
                        if (w_last_frame) begin
                            r_stop  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StIdle;
                        end else begin
                            r_valid <= 1'b1;
                            r_byte  <= HDR_BYTES[111:104];
                            r_cnt   <= 11'd1;
                            r_state <= StHdr;
                        end
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign Eth_Byte       = r_byte;
    assign Eth_Byte_Valid = r_valid;
    assign Eth_Pkt_Rdy    = r_pkt_rdy;
    assign Busy           = r_busy;
    assign Frames_Sent    = r_frames_sent;
    assign Done           = r_done;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Randomized scoreboard bench for eth_tx_sched with a simple eth_tx Tx_Busy responder.
module tb_eth_tx_sched;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic        Stop;
    logic [7:0]  Frame_Count;
    logic [10:0] Payload_Len;
    logic        Tx_Busy;
    logic [7:0]  Eth_Byte;
    logic        Eth_Byte_Valid;
    logic        Eth_Pkt_Rdy;
    logic        Busy;
    logic [15:0] Frames_Sent;
    logic        Done;

    eth_tx_sched dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Start          (Start),
        .Stop           (Stop),
        .Frame_Count    (Frame_Count),
        .Payload_Len    (Payload_Len),
        .Tx_Busy        (Tx_Busy),
        .Eth_Byte       (Eth_Byte),
        .Eth_Byte_Valid (Eth_Byte_Valid),
        .Eth_Pkt_Rdy    (Eth_Pkt_Rdy),
        .Busy           (Busy),
        .Frames_Sent    (Frames_Sent),
        .Done           (Done)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    byte unsigned exp_bytes[$];
    int exp_len[$];
    int mon_frames = 0;
    int cur_bytes = 0;
    int done_cnt = 0;
    bit prev_valid = 1'b0;
    int tx_falls = 0;
    int last_fall = 0;
    int seen_falls = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int val);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: observed %0d (cycle %0d)", name, val, cyc);
    endtask

    // Monitor: compares every presented byte and commit against the expected queues.
    always @(negedge Clk) begin
        if (Rst) begin
            cur_bytes  = 0;
            prev_valid = 1'b0;
        end else begin
            if (Eth_Byte_Valid) begin
                if (!prev_valid && tx_falls > seen_falls) begin
                    n_cmp++;
                    if (cyc - last_fall < 48) begin
                        n_bad++;
                        $display("FAIL ifg: frame began %0d clocks after Tx_Busy fell, need >= 48",
                                 cyc - last_fall);
                    end
                    seen_falls = tx_falls;
                end
                if (exp_bytes.size() == 0) fail_now("unexpected_byte", int'(Eth_Byte));
                else check("byte", Eth_Byte, exp_bytes.pop_front());
                cur_bytes++;
                if (Eth_Pkt_Rdy) fail_now("rdy_with_valid", 1);
            end else begin
                check("idle_byte_zero", Eth_Byte, 0);
            end
            if (Eth_Pkt_Rdy) begin
                if (exp_len.size() == 0) fail_now("unexpected_commit", cur_bytes);
                else check("frame_len", cur_bytes, exp_len.pop_front());
                cur_bytes = 0;
                mon_frames++;
            end
            if (Done) done_cnt++;
            prev_valid = Eth_Byte_Valid;
        end
    end

    // eth_tx stand-in: after each commit raise Tx_Busy for a random time.
    initial begin
        Tx_Busy = 1'b0;
        forever begin
            @(negedge Clk);
            if (Eth_Pkt_Rdy && !Rst) begin
                repeat ($urandom_range(1, 4)) @(posedge Clk);
                #1 Tx_Busy = 1'b1;
                repeat ($urandom_range(3, 20)) @(posedge Clk);
                #1 Tx_Busy = 1'b0;
                last_fall = cyc;
                tx_falls++;
            end
        end
    end

    function automatic int clamp_len(input int l);
        if (l < 46) return 46;
        if (l > 1500) return 1500;
        return l;
    endfunction

    task automatic push_frame(input int len, input int idx);
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] ety;
        dst = 48'hFFFF_FFFF_FFFF;
        src = 48'h02_00_00_00_00_01;
        ety = 16'h88B5;
        for (int i = 0; i < 6; i++) exp_bytes.push_back(byte'(dst >> (40 - 8 * i)));
        for (int i = 0; i < 6; i++) exp_bytes.push_back(byte'(src >> (40 - 8 * i)));
        exp_bytes.push_back(ety[15:8]);
        exp_bytes.push_back(ety[7:0]);
        for (int k = 0; k < len; k++) exp_bytes.push_back(byte'((k + idx) % 256));
        exp_len.push_back(14 + len);
    endtask

    task automatic pulse_start(input int fc, input int plen);
        @(posedge Clk);
        #1;
        Frame_Count = 8'(fc);
        Payload_Len = 11'(plen);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Frame_Count = 8'($urandom);
        Payload_Len = 11'($urandom);
    endtask

    task automatic wait_done(input int exp_fs, input int d0);
        bit got = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(negedge Clk);
            if (Done) begin
                got = 1'b1;
                check("frames_sent_at_done", Frames_Sent, exp_fs);
            end
        end
        if (!got) fail_now("done_timeout", exp_fs);
        @(negedge Clk);
        check("done_one_cycle", Done, 0);
        check("busy_after_done", Busy, 0);
        @(negedge Clk);
        check("done_count", done_cnt - d0, 1);
    endtask

    task automatic run(input int fc, input int plen, input bit start_in_hdr);
        int l;
        int d0;
        l  = clamp_len(plen);
        d0 = done_cnt;
        for (int f = 0; f < fc; f++) push_frame(l, f);
        pulse_start(fc, plen);
        if (start_in_hdr) begin
            @(posedge Clk);
            #1 Start = 1'b1;
            @(posedge Clk);
            #1 Start = 1'b0;
        end
        wait_done(fc, d0);
    endtask

    initial begin
        int l;
        int d0;
        int base;
        bit hit;
        Rst = 1'b1;
        Start = 1'b0;
        Stop = 1'b0;
        Frame_Count = '0;
        Payload_Len = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_valid", Eth_Byte_Valid, 0);
        check("rst_byte", Eth_Byte, 0);
        check("rst_rdy", Eth_Pkt_Rdy, 0);
        check("rst_busy", Busy, 0);
        check("rst_frames", Frames_Sent, 0);
        check("rst_done", Done, 0);
        Rst = 1'b0;

        run(1, 46, 1'b0);
        run(1, 10, 1'b0);
        run(1, 2000, 1'b0);
        run(3, 50, 1'b1);
        for (int r = 0; r < 4; r++) run($urandom_range(1, 3), $urandom_range(0, 120), r[0]);

        // Continuous mode, Stop during the payload of frame 5.
        l = clamp_len($urandom_range(46, 80));
        for (int f = 0; f < 5; f++) push_frame(l, f);
        base = mon_frames;
        d0 = done_cnt;
        pulse_start(0, l);
        hit = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            @(negedge Clk);
            if (mon_frames - base == 4 && cur_bytes > 20) hit = 1'b1;
        end
        if (!hit) fail_now("stop_window_timeout", mon_frames - base);
        @(posedge Clk);
        #1 Stop = 1'b1;
        @(posedge Clk);
        #1 Stop = 1'b0;
        wait_done(5, d0);
        repeat (200) @(negedge Clk);
        check("stop_frames_total", mon_frames - base, 5);

        // Start together with Stop in idle must not launch.
        @(posedge Clk);
        #1;
        Start = 1'b1;
        Stop = 1'b1;
        Frame_Count = 8'd1;
        Payload_Len = 11'd46;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Stop = 1'b0;
        repeat (5) @(negedge Clk);
        check("start_stop_busy", Busy, 0);
        check("start_stop_valid", Eth_Byte_Valid, 0);

        // Reset in the middle of a payload.
        push_frame(100, 0);
        pulse_start(1, 100);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge Clk);
            if (cur_bytes >= 44) hit = 1'b1;
        end
        if (!hit) fail_now("rst_window_timeout", cur_bytes);
        @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk);
        #1;
        check("midrst_valid", Eth_Byte_Valid, 0);
        check("midrst_byte", Eth_Byte, 0);
        check("midrst_rdy", Eth_Pkt_Rdy, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_frames", Frames_Sent, 0);
        check("midrst_done", Done, 0);
        Rst = 1'b0;
        exp_bytes.delete();
        exp_len.delete();
        repeat (300) @(negedge Clk);

        run(1, 46, 1'b0);
        repeat (20) @(negedge Clk);
        check("bytes_drained", exp_bytes.size(), 0);
        check("frames_drained", exp_len.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
